// File: rtl/alarm_pkg.sv
// Shared types, field limits and BCD step helper for the alarm-time setter.
package alarm_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_field_t;  // {msb, lsb}

  // 24-bit time bus layout: {hMSB, hLSB, mMSB, mLSB, sMSB, sLSB}
  typedef struct packed {
    bcd_digit_t hour_msb;
    bcd_digit_t hour_lsb;
    bcd_digit_t min_msb;
    bcd_digit_t min_lsb;
    bcd_digit_t sec_msb;
    bcd_digit_t sec_lsb;
  } time_bcd_t;

  localparam bcd_field_t FieldZero   = 8'h00;
  localparam bcd_field_t SecMax      = 8'h59;
  localparam bcd_field_t MinMax      = 8'h59;
  localparam bcd_field_t Hour24Max   = 8'h23;
  localparam bcd_field_t Hour12Max   = 8'h12;
  localparam bcd_field_t Hour12Min   = 8'h01;
  localparam bcd_field_t Hour12PreNn = 8'h11;

  // One wrap-around BCD step within [lo, hi]; simultaneous up and down cancel.
  function automatic bcd_field_t bcd_step(input bcd_field_t v, input logic up, input logic dn,
                                          input bcd_field_t lo, input bcd_field_t hi);
    bcd_field_t r;
    r = v;
    if (up && !dn) begin
      if (v == hi)                r = lo;
      else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
      else                        r = {v[7:4], v[3:0] + 4'd1};
    end else if (dn && !up) begin
      if (v == lo)                r = hi;
      else if (v[3:0] == 4'd0)    r = {v[7:4] - 4'd1, 4'd9};
      else                        r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_btn_repeat.sv
// Button edge detect with hold-to-repeat: step on press, after REPEAT_DLY cycles, then
// every REPEAT_PER cycles while held.
module alarm_btn_repeat #(
  parameter int unsigned REPEAT_DLY = 50_000_000,
  parameter int unsigned REPEAT_PER = 10_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic step_o
);

  localparam int unsigned CntMax = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned CntW   = $clog2(CntMax);

  logic            held_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q holds the cycles remaining until the next repeat step
  always_comb begin
    cnt_d  = '0;
    step_o = 1'b0;
    if (btn_i) begin
      if (!held_q) begin
        step_o = 1'b1;
        cnt_d  = CntW'(REPEAT_DLY - 1);
      end else if (cnt_q == '0) begin
        step_o = 1'b1;
        cnt_d  = CntW'(REPEAT_PER - 1);
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      held_q <= btn_i;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/alarm_set_counter.sv
// Alarm-time setter with auto-repeat buttons and a one-cycle match pulse.
// Define ALARM_DEC_EN to add the dn_* decrement buttons.
module alarm_set_counter
  import alarm_pkg::*;
#(
  parameter bit          H24        = 1'b1,
  parameter int unsigned REPEAT_DLY = 50_000_000,
  parameter int unsigned REPEAT_PER = 10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up_sec,
  input  logic        up_min,
  input  logic        up_hour,
`ifdef ALARM_DEC_EN
  input  logic        dn_sec,
  input  logic        dn_min,
  input  logic        dn_hour,
`endif
  input  logic        arm,
  input  logic [23:0] cur_time,
  input  logic        cur_pm,
  output logic [3:0]  outsecMSB,
  output logic [3:0]  outsecLSB,
  output logic [3:0]  outminMSB,
  output logic [3:0]  outminLSB,
  output logic [3:0]  outhourMSB,
  output logic [3:0]  outhourLSB,
  output logic        pm,
  output logic        alarm_match
);

  localparam bcd_field_t HourLo  = H24 ? FieldZero : Hour12Min;
  localparam bcd_field_t HourHi  = H24 ? Hour24Max : Hour12Max;
  localparam bcd_field_t HourRst = H24 ? FieldZero : Hour12Max;

  logic up_sec_step, up_min_step, up_hour_step;
  logic dn_sec_step, dn_min_step, dn_hour_step;

  alarm_btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_up_sec (
    .clk_i(clk), .rst_ni(reset), .btn_i(up_sec), .step_o(up_sec_step)
  );
  alarm_btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_up_min (
    .clk_i(clk), .rst_ni(reset), .btn_i(up_min), .step_o(up_min_step)
  );
  alarm_btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_up_hour (
    .clk_i(clk), .rst_ni(reset), .btn_i(up_hour), .step_o(up_hour_step)
  );

`ifdef ALARM_DEC_EN
  alarm_btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_dn_sec (
    .clk_i(clk), .rst_ni(reset), .btn_i(dn_sec), .step_o(dn_sec_step)
  );
  alarm_btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_dn_min (
    .clk_i(clk), .rst_ni(reset), .btn_i(dn_min), .step_o(dn_min_step)
  );
  alarm_btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_dn_hour (
    .clk_i(clk), .rst_ni(reset), .btn_i(dn_hour), .step_o(dn_hour_step)
  );
`else
  assign dn_sec_step  = 1'b0;
  assign dn_min_step  = 1'b0;
  assign dn_hour_step = 1'b0;
`endif

  bcd_field_t sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic       pm_q, pm_d, eq_q, eq_d, match_q, match_d;
  time_bcd_t  alarm_time;

  assign alarm_time = {hour_q, min_q, sec_q};

  always_comb begin
    sec_d  = bcd_step(sec_q, up_sec_step, dn_sec_step, FieldZero, SecMax);
    min_d  = bcd_step(min_q, up_min_step, dn_min_step, FieldZero, MinMax);
    hour_d = bcd_step(hour_q, up_hour_step, dn_hour_step, HourLo, HourHi);
    pm_d   = 1'b0;
    if (!H24) begin
      // Meridiem flips only when crossing the 11/12 boundary, in either direction
      pm_d = pm_q ^ ((up_hour_step && !dn_hour_step && hour_q == Hour12PreNn) ||
                     (dn_hour_step && !up_hour_step && hour_q == Hour12Max));
    end
    eq_d    = arm && (alarm_time == cur_time) && (H24 || (pm_q == cur_pm));
    match_d = eq_d && !eq_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_q   <= FieldZero;
      min_q   <= FieldZero;
      hour_q  <= HourRst;
      pm_q    <= 1'b0;
      eq_q    <= 1'b0;
      match_q <= 1'b0;
    end else begin
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      pm_q    <= pm_d;
      eq_q    <= eq_d;
      match_q <= match_d;
    end
  end

  assign outsecMSB   = alarm_time.sec_msb;
  assign outsecLSB   = alarm_time.sec_lsb;
  assign outminMSB   = alarm_time.min_msb;
  assign outminLSB   = alarm_time.min_lsb;
  assign outhourMSB  = alarm_time.hour_msb;
  assign outhourLSB  = alarm_time.hour_lsb;
  assign pm          = pm_q;
  assign alarm_match = match_q;

endmodule

// File: tb/tb_alarm_set_counter.sv
// Self-checking bench for alarm_set_counter: 24-hour and 12-hour instances, short repeat timing.
module tb_alarm_set_counter;

  localparam int unsigned Dly = 4;
  localparam int unsigned Per = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        up_sec = 1'b0, up_min = 1'b0, up_hour = 1'b0;
`ifdef ALARM_DEC_EN
  logic        dn_sec = 1'b0, dn_min = 1'b0, dn_hour = 1'b0;
`endif
  logic        arm = 1'b0;
  logic [23:0] cur_time = 24'h0;
  logic        cur_pm = 1'b0;

  logic [3:0]  a_sm, a_sl, a_mm, a_ml, a_hm, a_hl;
  logic [3:0]  b_sm, b_sl, b_mm, b_ml, b_hm, b_hl;
  logic        a_pm, a_match, b_pm, b_match;
  logic [23:0] ta, tb;

  assign ta = {a_hm, a_hl, a_mm, a_ml, a_sm, a_sl};
  assign tb = {b_hm, b_hl, b_mm, b_ml, b_sm, b_sl};

  always #5 clk = ~clk;

  alarm_set_counter #(.H24(1'b1), .REPEAT_DLY(Dly), .REPEAT_PER(Per)) dut24 (
    .clk(clk), .reset(reset), .up_sec(up_sec), .up_min(up_min), .up_hour(up_hour),
`ifdef ALARM_DEC_EN
    .dn_sec(dn_sec), .dn_min(dn_min), .dn_hour(dn_hour),
`endif
    .arm(arm), .cur_time(cur_time), .cur_pm(cur_pm),
    .outsecMSB(a_sm), .outsecLSB(a_sl), .outminMSB(a_mm), .outminLSB(a_ml),
    .outhourMSB(a_hm), .outhourLSB(a_hl), .pm(a_pm), .alarm_match(a_match)
  );

  alarm_set_counter #(.H24(1'b0), .REPEAT_DLY(Dly), .REPEAT_PER(Per)) dut12 (
    .clk(clk), .reset(reset), .up_sec(up_sec), .up_min(up_min), .up_hour(up_hour),
`ifdef ALARM_DEC_EN
    .dn_sec(dn_sec), .dn_min(dn_min), .dn_hour(dn_hour),
`endif
    .arm(arm), .cur_time(cur_time), .cur_pm(cur_pm),
    .outsecMSB(b_sm), .outsecLSB(b_sl), .outminMSB(b_mm), .outminLSB(b_ml),
    .outhourMSB(b_hm), .outhourLSB(b_hl), .pm(b_pm), .alarm_match(b_match)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: up_sec = v;
      1: up_min = v;
      2: up_hour = v;
`ifdef ALARM_DEC_EN
      3: dn_sec = v;
      4: dn_min = v;
      5: dn_hour = v;
`endif
      default: ;
    endcase
  endtask

  task automatic press(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      set_btn(which, 1'b1);
      cyc();
      set_btn(which, 1'b0);
      cyc();
    end
  endtask

  task automatic do_reset();
    for (int w = 0; w < 6; w++) set_btn(w, 1'b0);
    arm = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  up;   // {hour, min, sec}
    logic [23:0] exp;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] hold_min[10];

  initial begin
    #4000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{3'b001, 24'h000001};
    vecs[1]  = '{3'b000, 24'h000001};
    vecs[2]  = '{3'b011, 24'h000102};
    vecs[3]  = '{3'b000, 24'h000102};
    vecs[4]  = '{3'b100, 24'h010102};
    vecs[5]  = '{3'b100, 24'h010102};
    vecs[6]  = '{3'b100, 24'h010102};
    vecs[7]  = '{3'b100, 24'h010102};
    vecs[8]  = '{3'b100, 24'h020102};
    vecs[9]  = '{3'b100, 24'h020102};
    vecs[10] = '{3'b100, 24'h030102};
    vecs[11] = '{3'b000, 24'h030102};
    hold_min = '{8'h59, 8'h59, 8'h59, 8'h59, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02};

    // Reset state
    #12;
    check("rst_time24", 32'(ta), 32'h000000);
    check("rst_pm24", 32'(a_pm), 0);
    check("rst_match24", 32'(a_match), 0);
    check("rst_time12", 32'(tb), 32'h120000);
    check("rst_pm12", 32'(b_pm), 0);
    @(negedge clk);
    reset = 1'b1;

    // Table: presses, same-cycle multi-field, hold repeat
    for (int i = 0; i < 12; i++) begin
      {up_hour, up_min, up_sec} = vecs[i].up;
      cyc();
      check($sformatf("vec%0d", i), 32'(ta), 32'(vecs[i].exp));
    end
    {up_hour, up_min, up_sec} = 3'b000;

    // 24-hour hour wrap
    do_reset();
    press(2, 23);
    check("h24_23", 32'(ta), 32'h230000);
    press(2, 1);
    check("h24_wrap", 32'(ta), 32'h000000);

    // 12-hour order and pm toggling
    do_reset();
    press(2, 11);
    check("h12_11", 32'(tb), 32'h110000);
    check("h12_11_pm", 32'(b_pm), 0);
    check("h24_pm_const", 32'(a_pm), 0);
    press(2, 1);
    check("h12_12", 32'(tb), 32'h120000);
    check("h12_12_pm", 32'(b_pm), 1);
    press(2, 1);
    check("h12_01", 32'(tb), 32'h010000);
    check("h12_01_pm", 32'(b_pm), 1);
`ifdef ALARM_DEC_EN
    press(5, 1);
    check("h12_dn_12", 32'(tb), 32'h120000);
    check("h12_dn_12_pm", 32'(b_pm), 1);
    press(5, 1);
    check("h12_dn_11", 32'(tb), 32'h110000);
    check("h12_dn_11_pm", 32'(b_pm), 0);
`endif

    // Hold repeat across minute wrap, no carry into hours
    do_reset();
    press(1, 58);
    check("min_58", 32'(ta), 32'h005800);
    up_min = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      check($sformatf("hold_min_c%0d", c + 1), 32'(ta), {8'h0, 8'h00, hold_min[c], 8'h00});
    end
    up_min = 1'b0;
    cyc();

    // Simultaneous steps
    do_reset();
    up_sec = 1'b1;
    up_min = 1'b1;
    cyc();
    check("sec_min_same", 32'(ta), 32'h000101);
    up_sec = 1'b0;
    up_min = 1'b0;
    cyc();
`ifdef ALARM_DEC_EN
    press(0, 29);
    check("sec_30", 32'(ta), 32'h000130);
    up_sec = 1'b1;
    dn_sec = 1'b1;
    cyc();
    check("sec_cancel", 32'(ta), 32'h000130);
    up_sec = 1'b0;
    dn_sec = 1'b0;
    cyc();
    press(4, 2);
    check("min_dn_wrap", 32'(ta), 32'h005930);
`endif

    // Match pulse
    do_reset();
    press(2, 7);
    press(1, 30);
    check("alarm_set", 32'(ta), 32'h073000);
    cur_time = 24'h072959;
    arm = 1'b1;
    cyc();
    cyc();
    check("match_pre", 32'(a_match), 0);
    cur_time = 24'h073000;
    cyc();
    check("match_pulse", 32'(a_match), 1);
    check("match_pulse12", 32'(b_match), 1);
    for (int c = 0; c < 4; c++) begin
      cyc();
      check($sformatf("match_held%0d", c), 32'(a_match), 0);
    end
    arm = 1'b0;
    cur_time = 24'h072959;
    cyc();
    cur_time = 24'h073000;
    for (int c = 0; c < 5; c++) begin
      cyc();
      check($sformatf("match_disarmed%0d", c), 32'(a_match), 0);
    end
    arm = 1'b1;
    cur_time = 24'h073001;
    cyc();
    check("edit_pre", 32'(a_match), 0);
    up_sec = 1'b1;
    cyc();
    check("edit_step", 32'(a_match), 0);
    up_sec = 1'b0;
    cyc();
    check("edit_pulse", 32'(a_match), 1);
    cyc();
    check("edit_after", 32'(a_match), 0);
    arm = 1'b0;

    // Reset mid-repeat, then held button counts as a fresh press
    do_reset();
    up_sec = 1'b1;
    for (int c = 0; c < 7; c++) cyc();
    check("repeat_pre_rst", 32'(ta), 32'h000003);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_time", 32'(ta), 32'h000000);
    check("async_rst_match", 32'(a_match), 0);
    @(negedge clk);
    reset = 1'b1;
    cyc();
    check("rst_held_step", 32'(ta), 32'h000001);
    cyc();
    check("rst_held_no_rep", 32'(ta), 32'h000001);
    up_sec = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_set_counter.md
ALARM_SET_COUNTER -- requirements
Module: alarm_set_counter

Interface
REQ-001 Parameter H24, default 1, selects 24-hour mode (1) or 12-hour mode with AM/PM (0).
REQ-002 Parameter REPEAT_DLY, default 50_000_000, is the hold time in cycles before auto-repeat starts (>=2).
REQ-003 Parameter REPEAT_PER, default 10_000_000, is the auto-repeat period in cycles (>=1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 up_sec, up_min, up_hour  input  1 each  synchronous, debounced button levels; 1 = pressed.
REQ-007 dn_sec, dn_min, dn_hour  input  1 each  decrement button levels; present only with ALARM_DEC_EN.
REQ-008 arm  input  1  alarm armed when 1.
REQ-009 cur_time  input  24  current time BCD {hMSB,hLSB,mMSB,mLSB,sMSB,sLSB}; cur_pm  input  1  current PM flag (ignored when H24=1).
REQ-010 outsecMSB, outsecLSB, outminMSB, outminLSB, outhourMSB, outhourLSB  output  4 each  registered alarm time BCD digits.
REQ-011 pm  output  1  alarm PM flag; constant 0 when H24=1.
REQ-012 alarm_match  output  1  registered one-cycle match pulse.

Function
REQ-013 Each button generates a step on the first cycle it is seen high (rising edge vs. previous-cycle sample).
REQ-014 Held continuously, a button generates a further step after REPEAT_DLY cycles, then every REPEAT_PER cycles until released; release restarts the hold counter.
REQ-015 Step takes effect on outputs one cycle after the button sample that produced it.
REQ-016 Fields are independent: seconds and minutes wrap 59->00 on increment and 00->59 on decrement, with no carry or borrow into other fields.
REQ-017 Hours, H24=1: range 00-23, wrap 23->00 / 00->23.
REQ-018 Hours, H24=0: range 01-12, increment order 12,01,...,11,12; pm toggles on 11->12 increment and on 12->11 decrement.
REQ-019 Up and down steps for the same field in the same cycle cancel: field unchanged.
REQ-020 Steps on different fields in the same cycle are all applied.
REQ-021 Outputs are always valid BCD; no digit ever exceeds its field range.
REQ-022 alarm_match pulses for exactly one cycle on the cycle after (arm=1 and time digits equal cur_time and, when H24=0, pm equals cur_pm) becomes true from false.
REQ-023 Held equality produces no further pulses; equality created by editing the alarm also generates a pulse; arm low suppresses pulses and clears the edge history.

Reset
REQ-024 reset low asynchronously forces all digits to 0 (H24=1: 00:00:00) or hours to 12 with minutes/seconds 00 (H24=0), pm=0, alarm_match=0, all edge and repeat counters cleared.
REQ-025 After reset release, a button already held counts as a new press on the first clock edge.
REQ-026 Reset mid-hold or mid-repeat aborts the repeat sequence; no step is generated by reset itself.

Configuration
REQ-027 Macro ALARM_DEC_EN defined: dn_* ports exist with decrement behaviour and auto-repeat identical to up_*.
REQ-028 ALARM_DEC_EN undefined: dn_* ports and decrement logic absent; behaviour is increment-only, all other requirements unchanged.

Structure
REQ-029 Package alarm_pkg holds the BCD digit type, field limit constants (59, 23, 12, 01) and the 24-bit time bus field layout.
REQ-030 Sub-module alarm_btn_repeat implements edge detection and hold/auto-repeat counting, one instance per button, parameterised by REPEAT_DLY and REPEAT_PER.

Verification
REQ-031 H24=1, reset then one up_hour press from 23:00:00 -> 00:00:00, minutes and seconds unchanged.
REQ-032 H24=0, hours 11 pm=0, one up_hour press -> 12 pm=1; next press -> 01 pm=1; dn_hour from 12 pm=1 -> 11 pm=0.
REQ-033 REPEAT_DLY=4, REPEAT_PER=2, up_min held 10 cycles from 58 -> steps at cycles 1,5,7,9 -> 58,59,00,01,02 with no hour change.
REQ-034 up_sec and dn_sec asserted same cycle at 30 -> stays 30; up_sec and up_min same cycle from 00:00 -> 00:01:01.
REQ-035 arm=1, alarm 07:30:00, cur_time stepped 07:29:59 -> 07:30:00 held 5 cycles -> alarm_match high exactly one cycle; arm=0 repeat -> no pulse.
REQ-036 reset asserted mid-repeat with up_sec held -> outputs reset immediately, alarm_match 0; release with button held -> single step to 01 on next edge.
